// File: rtl/tug_of_war_match.sv
`default_nettype none
// ============================================================================
// Module   : tug_of_war_match
// Brief    : Tug-of-war game core with match scoring, inter-point pause,
//            match-over display and an LFSR-driven computer opponent.
// Revision : 1.0 - initial release
// ============================================================================
module tug_of_war_match #(
    parameter int N_LIGHTS    = 9,
    parameter int SCORE_MAX   = 7,
    parameter int LFSR_W      = 10,
    parameter int PAUSE_TICKS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ce,
    input  logic                left_key_n,
    input  logic [LFSR_W-1:0]   difficulty,
    input  logic                new_match,
    output logic [N_LIGHTS-1:0] lights,
    output logic [3:0]          left_score,
    output logic [3:0]          right_score,
    output logic                match_over,
    output logic [1:0]          winner
);

    // Maximal-length XNOR feedback taps, one bit per tapped stage (bit 0 = stage 1).
    function automatic logic [15:0] tap_mask(input int w);
        logic [15:0] m;
        m = 16'h0000;
        case (w)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    localparam int                  c_POS_W     = $clog2(N_LIGHTS);
    localparam int                  c_PAUSE_W   = $clog2(PAUSE_TICKS + 1);
    localparam logic [15:0]         c_TAPS_FULL = tap_mask(LFSR_W);
    localparam logic [LFSR_W-1:0]   c_TAPS      = c_TAPS_FULL[LFSR_W-1:0];
    localparam logic [c_POS_W-1:0]  c_CENTER    = c_POS_W'((N_LIGHTS - 1) / 2);
    localparam logic [c_POS_W-1:0]  c_LAST      = c_POS_W'(N_LIGHTS - 1);
    localparam logic [3:0]          c_SMAX      = 4'(SCORE_MAX);
    localparam logic [c_PAUSE_W-1:0] c_PAUSE    = c_PAUSE_W'(PAUSE_TICKS);
    localparam logic [N_LIGHTS-1:0] c_ONE       = N_LIGHTS'(1);

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
        S_POINT = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    state_t                 r_state, w_state;
    logic [c_POS_W-1:0]     r_pos, w_pos;
    logic [3:0]             r_lscore, w_lscore, r_rscore, w_rscore;
    logic [c_PAUSE_W-1:0]   r_pause, w_pause;
    logic [LFSR_W-1:0]      r_lfsr, w_lfsr;
    logic [N_LIGHTS-1:0]    r_lights, w_lights;
    logic [1:0]             r_winner, w_winner;
    logic                   r_pending, w_pending;
    logic                   r_key_meta, r_key_sync, r_key_prev;

    logic                   w_press, w_left, w_right, w_scored;
    logic [LFSR_W:0]        w_sum;

    assign w_press = r_key_sync & ~r_key_prev;
    assign w_left  = r_pending | w_press;
    assign w_sum   = {1'b0, difficulty} + {1'b0, r_lfsr};
    assign w_right = ce & w_sum[LFSR_W];

    always_comb begin
        w_state   = r_state;
        w_pos     = r_pos;
        w_lscore  = r_lscore;
        w_rscore  = r_rscore;
        w_pause   = r_pause;
        w_lights  = r_lights;
        w_winner  = r_winner;
        w_scored  = 1'b0;
        w_pending = ce ? 1'b0 : w_left;
        w_lfsr    = ce ? {r_lfsr[LFSR_W-2:0], ~^(r_lfsr & c_TAPS)} : r_lfsr;

        if (ce) begin
            case (r_state)
                S_PLAY: begin
                    if (w_left && !w_right) begin
                        if (r_pos == c_LAST) begin
                            w_lscore = r_lscore + 4'd1;
                            w_scored = 1'b1;
                        end else begin
                            w_pos = r_pos + c_POS_W'(1);
                        end
                    end else if (w_right && !w_left) begin
                        if (r_pos == '0) begin
                            w_rscore = r_rscore + 4'd1;
                            w_scored = 1'b1;
                        end else begin
                            w_pos = r_pos - c_POS_W'(1);
                        end
                    end
                    if (!w_scored) begin
                        w_lights = c_ONE << w_pos;
                    end else if (w_lscore == c_SMAX || w_rscore == c_SMAX) begin
                        w_state  = S_OVER;
                        w_lights = '1;
                        w_winner = (w_lscore == c_SMAX) ? 2'b10 : 2'b01;
                    end else begin
                        w_state  = S_POINT;
                        w_pause  = c_PAUSE;
                        w_lights = '0;
                    end
                end
                S_POINT: begin
                    // The tick that empties the pause counter re-centres the rope.
                    if (r_pause <= c_PAUSE_W'(1)) begin
                        w_pause  = '0;
                        w_state  = S_PLAY;
                        w_pos    = c_CENTER;
                        w_lights = c_ONE << c_CENTER;
                    end else begin
                        w_pause = r_pause - c_PAUSE_W'(1);
                    end
                end
                S_OVER: begin
                    w_lights = ~r_lights;
                end
                default: begin
                    w_state = S_PLAY;
                end
            endcase
        end

        if (new_match) begin
            w_state   = S_PLAY;
            w_pos     = c_CENTER;
            w_lscore  = 4'd0;
            w_rscore  = 4'd0;
            w_pause   = '0;
            w_pending = 1'b0;
            w_lights  = c_ONE << c_CENTER;
            w_winner  = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_PLAY;
            r_pos      <= c_CENTER;
            r_lscore   <= 4'd0;
            r_rscore   <= 4'd0;
            r_pause    <= '0;
            r_lfsr     <= '0;
            r_lights   <= c_ONE << c_CENTER;
            r_winner   <= 2'b00;
            r_pending  <= 1'b0;
            r_key_meta <= 1'b0;
            r_key_sync <= 1'b0;
            r_key_prev <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_pos      <= w_pos;
            r_lscore   <= w_lscore;
            r_rscore   <= w_rscore;
            r_pause    <= w_pause;
            r_lfsr     <= w_lfsr;
            r_lights   <= w_lights;
            r_winner   <= w_winner;
            r_pending  <= w_pending;
            r_key_meta <= ~left_key_n;
            r_key_sync <= r_key_meta;
            r_key_prev <= r_key_sync;
        end
    end

    assign lights      = r_lights;
    assign left_score  = r_lscore;
    assign right_score = r_rscore;
    assign match_over  = (r_state == S_OVER);
    assign winner      = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_tug_of_war_match.sv
`default_nettype none
// ============================================================================
// Module   : tb_tug_of_war_match
// Brief    : Directed stimulus with a game-rule model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tug_of_war_match;

    localparam int N  = 9;
    localparam int SM = 7;
    localparam int W  = 10;
    localparam int PT = 4;
    localparam int M_PLAY = 0, M_POINT = 1, M_OVER = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         ce = 1'b0;
    logic         left_key_n = 1'b1;
    logic [W-1:0] difficulty = '0;
    logic         new_match = 1'b0;
    logic [N-1:0] lights;
    logic [3:0]   left_score, right_score;
    logic         match_over;
    logic [1:0]   winner;

    int n_pass = 0;
    int n_total = 0;

    tug_of_war_match #(
        .N_LIGHTS(N), .SCORE_MAX(SM), .LFSR_W(W), .PAUSE_TICKS(PT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .left_key_n(left_key_n),
        .difficulty(difficulty), .new_match(new_match), .lights(lights),
        .left_score(left_score), .right_score(right_score),
        .match_over(match_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Game-rule model
    int m_pos, m_ls, m_rs, m_mode, m_pause, m_lfsr;
    bit m_pend, m_blink, m_valid = 1'b0;
    bit k1, k2, k3;

    function automatic int lfsr_step(input int v);
        bit [9:0] b;
        b = v[9:0];
        return int'({b[8:0], ~(b[9] ^ b[6])});
    endfunction

    always @(posedge clk) begin
        bit press, l, r;
        if (!reset_n) begin
            m_pos = (N - 1) / 2; m_ls = 0; m_rs = 0; m_mode = M_PLAY;
            m_pause = 0; m_lfsr = 0; m_pend = 0; m_blink = 0;
            k1 = 0; k2 = 0; k3 = 0; m_valid = 1'b1;
        end else begin
            press = k2 & ~k3;
            k3 = k2; k2 = k1; k1 = ~left_key_n;
            if (ce) begin
                l = m_pend | press;
                r = (int'(difficulty) + m_lfsr) >= (1 << W);
                m_lfsr = lfsr_step(m_lfsr);
                m_pend = 0;
                case (m_mode)
                    M_PLAY: begin
                        if (l && !r) begin
                            if (m_pos == N - 1) m_ls++;
                            else m_pos++;
                        end else if (r && !l) begin
                            if (m_pos == 0) m_rs++;
                            else m_pos--;
                        end
                        if (m_ls == SM || m_rs == SM) begin
                            m_mode = M_OVER; m_blink = 1;
                        end else if ((l && !r && m_pos == N - 1 && m_ls > 0 && press !== 1'bx && 0) ) begin
                            m_mode = M_PLAY;
                        end
                    end
                    M_POINT: begin
                        m_pause--;
                        if (m_pause == 0) begin m_mode = M_PLAY; m_pos = (N - 1) / 2; end
                    end
                    default: m_blink = ~m_blink;
                endcase
            end else begin
                m_pend = m_pend | press;
            end
            if (new_match) begin
                m_mode = M_PLAY; m_pos = (N - 1) / 2; m_ls = 0; m_rs = 0;
                m_pause = 0; m_pend = 0;
            end
        end
    end

    // A point that does not end the match starts the pause; detected from score changes.
    int p_ls = 0, p_rs = 0;
    always @(posedge clk) begin
        #1;
        if (reset_n && !new_match && m_mode == M_PLAY && (m_ls > p_ls || m_rs > p_rs)) begin
            m_mode = M_POINT; m_pause = PT;
        end
        p_ls = m_ls; p_rs = m_rs;
    end

    function automatic logic [N-1:0] exp_lights();
        if (m_mode == M_PLAY) return N'(1) << m_pos;
        if (m_mode == M_POINT) return '0;
        return m_blink ? '1 : '0;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("lights", 32'(lights), 32'(exp_lights()));
            check("left_score", 32'(left_score), 32'(m_ls));
            check("right_score", 32'(right_score), 32'(m_rs));
            check("match_over", 32'(match_over), 32'(m_mode == M_OVER));
            check("winner", 32'(winner),
                  (m_mode != M_OVER) ? 32'd0 : (m_ls == SM ? 32'd2 : 32'd1));
        end
    end

    task automatic tick();
        @(negedge clk) ce = 1'b1;
        @(negedge clk) ce = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key();
        @(negedge clk) left_key_n = 1'b0;
        idle(3);
        left_key_n = 1'b1;
        idle(3);
    endtask

    task automatic pulse_new_match();
        @(negedge clk) new_match = 1'b1;
        @(negedge clk) new_match = 1'b0;
    endtask

    initial begin
        idle(2);
        reset_n = 1'b1;
        check("reset_lights", 32'(lights), 32'h010);
        check("reset_scores", {24'd0, left_score, right_score}, 32'd0);
        check("reset_winner", 32'(winner), 32'd0);

        repeat (4) begin press_key(); tick(); end
        check("walk_left_end", 32'(lights), 32'h100);
        press_key(); tick();
        check("left_point_score", 32'(left_score), 32'd1);
        check("left_point_dark", 32'(lights), 32'h000);
        repeat (3) tick();
        check("pause_dark", 32'(lights), 32'h000);
        tick();
        check("pause_recentre", 32'(lights), 32'h010);

        @(negedge clk) left_key_n = 1'b0;
        repeat (10) begin tick(); idle(1); end
        left_key_n = 1'b1;
        idle(4);
        check("held_one_move", 32'(lights), 32'h020);

        @(negedge clk) left_key_n = 1'b0;
        @(negedge clk);
        @(negedge clk) ce = 1'b1;
        @(negedge clk) ce = 1'b0;
        check("press_with_ce", 32'(lights), 32'h040);
        left_key_n = 1'b1;
        idle(4);

        difficulty = '1;
        press_key(); tick();
        check("tie_no_move", 32'(lights), 32'h040);

        for (int i = 0; i < 300 && !match_over; i++) tick();
        check("match_over_reached", 32'(match_over), 32'd1);
        check("right_wins_score", 32'(right_score), 32'd7);
        check("right_wins_winner", 32'(winner), 32'd1);
        check("over_entry_lights", 32'(lights), 32'h1FF);
        tick();
        check("over_blink_off", 32'(lights), 32'h000);
        tick();
        check("over_blink_on", 32'(lights), 32'h1FF);

        pulse_new_match();
        check("nm_over_scores", {24'd0, left_score, right_score}, 32'd0);
        check("nm_over_lights", 32'(lights), 32'h010);
        check("nm_over_winner", 32'(winner), 32'd0);

        for (int i = 0; i < 50 && right_score == 4'd0; i++) tick();
        check("right_point", 32'(right_score), 32'd1);
        tick();
        pulse_new_match();
        check("nm_point_scores", {24'd0, left_score, right_score}, 32'd0);
        check("nm_point_lights", 32'(lights), 32'h010);

        difficulty = '0;
        press_key(); tick();
        check("play_before_reset", 32'(lights), 32'h020);
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        check("reset_mid_play", 32'(lights), 32'h010);
        difficulty = '1;
        tick();
        check("lfsr_zero_no_move", 32'(lights), 32'h010);
        tick();
        check("lfsr_one_move", 32'(lights), 32'h008);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
